// File: rtl/arriskv_fetch.sv
// arriskv_fetch: instruction fetch unit with one outstanding imem request and
// a small registered instruction buffer toward decode.
// Build option: define ARRISKV_FETCH_MISALIGN_EN to halt on misaligned redirects.
module arriskv_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        fetch_misaligned
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_FETCH      = 2'd0,
    ST_WAIT       = 2'd1,
    ST_FLUSH_WAIT = 2'd2,
    ST_HALT       = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        started_q;
  logic        misaligned_q, misaligned_d;

  logic [31:0]      data_q [FIFO_DEPTH];
  logic [31:0]      data_d [FIFO_DEPTH];
  logic [31:0]      addr_q [FIFO_DEPTH];
  logic [31:0]      addr_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        req_c;
  logic        push_c;
  logic        pop_c;
  logic        flush_c;
  logic        nonempty_c;
  logic [31:0] redir_pc_c;
  logic        redir_bad_c;

  // Redirect target conditioning: either flag misalignment or drop the low bits
`ifdef ARRISKV_FETCH_MISALIGN_EN
  assign redir_pc_c  = redirect_pc;
  assign redir_bad_c = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_pc_c  = redirect_pc & 32'hFFFF_FFFC;
  assign redir_bad_c = 1'b0;
`endif

  // Request only after the first clock edge out of reset, with a slot reserved
  assign nonempty_c = (count_q != '0);
  assign req_c      = started_q && (state_q == ST_FETCH) && (count_q < DEPTH_C);
  assign pop_c      = nonempty_c && instr_ready;

  assign imem_req         = req_c;
  assign imem_addr        = pc_q;
  assign instr_valid      = nonempty_c;
  assign instr_data       = data_q[rd_ptr_q];
  assign instr_pc         = addr_q[rd_ptr_q];
  assign fetch_misaligned = misaligned_q;

  // Fetch FSM next state; a redirect overrides the normal progression
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    misaligned_d = misaligned_q;
    push_c       = 1'b0;
    flush_c      = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (req_c && imem_gnt) begin
          req_addr_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          push_c  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FLUSH_WAIT: begin
        if (imem_rvalid) begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_FETCH;
    endcase

    if (redirect_valid) begin
      flush_c = 1'b1;
      push_c  = 1'b0;
      pc_d    = redir_pc_c;
      if (redir_bad_c) begin
        state_d      = ST_HALT;
        misaligned_d = 1'b1;
      end else begin
        misaligned_d = 1'b0;
        unique case (state_q)
          ST_FETCH:      state_d = (req_c && imem_gnt) ? ST_FLUSH_WAIT : ST_FETCH;
          ST_WAIT:       state_d = imem_rvalid ? ST_FETCH : ST_FLUSH_WAIT;
          ST_FLUSH_WAIT: state_d = imem_rvalid ? ST_FETCH : ST_FLUSH_WAIT;
          default:       state_d = ST_FETCH;
        endcase
      end
    end
  end

  // Fetch control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      started_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      started_q    <= 1'b1;
      misaligned_q <= misaligned_d;
    end
  end

  // Instruction buffer update; flush wins over push and pop
  always_comb begin
    data_d   = data_q;
    addr_d   = addr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        data_d[wr_ptr_q] = imem_rdata;
        addr_d[wr_ptr_q] = req_addr_q;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Instruction buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      data_q   <= data_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_arriskv_fetch.sv
// tb_arriskv_fetch: directed table, hand-written corner sequences and random
// traffic against a transaction-level fetch model.
module tb_arriskv_fetch;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        fetch_misaligned;

  arriskv_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_data       (instr_data),
    .instr_pc         (instr_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  // Reference model: decode-visible queue plus fetch bookkeeping
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic        m_ost;
  logic        m_kill;
  logic        m_halt;
  logic        m_started;

  // Bench memory: one transaction, programmable latency
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_wait;
  int          cur_lat;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic exp_req();
    return m_started && !m_ost && (mq.size() < int'(DEPTH)) && !m_halt;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_chk();
    logic e;
    e = exp_req();
    chk("m_req", 32'(imem_req), 32'(e));
    if (e) chk("m_addr", imem_addr, m_pc);
    chk("m_valid", 32'(instr_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("m_ipc", instr_pc, mq[0].pc);
      chk("m_idata", instr_data, mq[0].data);
    end
    chk("m_misal", 32'(fetch_misaligned), 32'(m_halt));
  endtask

  // One clock: drive inputs now, advance the model, compare at the next negedge
  task automatic cycle(input logic gnt_en, input logic rdy, input logic redir,
                       input logic [31:0] rpc);
    logic        rv;
    logic        gnt_hit;
    logic [31:0] tgt;
    logic        bad;
    ent_t        e;
    rv             = mem_busy && (mem_wait == 0);
    imem_gnt       = gnt_en;
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_data(mem_addr) : 32'hDEAD_BEEF;
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    gnt_hit        = exp_req() && gnt_en;

    if (rv) mem_busy = 1'b0;
    else if (mem_busy) mem_wait--;
    if (imem_req && gnt_en) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_wait = cur_lat - 1;
    end

`ifdef ARRISKV_FETCH_MISALIGN_EN
    tgt = rpc;
    bad = (rpc[1:0] != 2'b00);
`else
    tgt = {rpc[31:2], 2'b00};
    bad = 1'b0;
`endif
    if (redir) begin
      mq.delete();
      m_pc   = tgt;
      m_halt = bad;
      if (rv) m_ost = 1'b0;
      if (gnt_hit) m_ost = 1'b1;
      m_kill = m_ost;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (rv) begin
        if (!m_kill) begin
          e.pc   = m_addr;
          e.data = mem_data(m_addr);
          mq.push_back(e);
        end
        m_ost = 1'b0;
      end
      if (gnt_hit) begin
        m_ost  = 1'b1;
        m_kill = 1'b0;
        m_addr = m_pc;
        m_pc   = m_pc + 32'd4;
      end
    end
    m_started = 1'b1;
    @(negedge clk);
    model_chk();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_misal", 32'(fetch_misaligned), 32'd0);
    mq.delete();
    m_pc = RPC; m_addr = RPC; m_ost = 1'b0; m_kill = 1'b0; m_halt = 1'b0; m_started = 1'b0;
    mem_busy = 1'b0; mem_addr = '0; mem_wait = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic        gnt;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    bit seen;
    cur_lat = 1;
    // Each row: outputs expected now, then inputs for the following clock
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h108, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h10C, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h108};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h110, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h204, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200};

    do_reset();

    // Start-up stream and redirect over an in-flight 0x10C fetch
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_ipc", i), instr_pc, vecs[i].exp_pc);
      cycle(vecs[i].gnt, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
    end

    // Decode stall: buffer fills to two and requests stop
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    chk("stall_head", instr_pc, 32'h200);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_second", instr_pc, 32'h204);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_drained", 32'(instr_valid), 32'd0);

    // Reset with a request in flight
    cur_lat = 3;
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    do_reset();
    cur_lat = 1;

    // Grant held low: address must stay put
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("first_addr", imem_addr, 32'h100);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("nognt_req", 32'(imem_req), 32'd1);
      chk("nognt_addr", imem_addr, 32'h104);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
    end
    chk("nognt_addr_end", imem_addr, 32'h104);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("nognt_push", instr_pc, 32'h104);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("nognt_single", 32'(instr_valid), 32'd0);

    // Address wrap at the top of the space
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_next", imem_addr, 32'h0000_0000);
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);

    // Redirects while a slow response is pending
    cur_lat = 3;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'h400);
    chk("fw_req0", 32'(imem_req), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 32'h500);
    chk("fw_req1", 32'(imem_req), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("fw_resume", imem_addr, 32'h500);
    chk("fw_dropped", 32'(instr_valid), 32'd0);
    cur_lat = 1;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      seen = instr_valid;
    end
    if (seen) chk("fw_ipc", instr_pc, 32'h500);
    else chk("fw_timeout", 32'(instr_valid), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // Misaligned redirect
    cycle(1'b0, 1'b1, 1'b1, 32'h202);
`ifdef ARRISKV_FETCH_MISALIGN_EN
    chk("mis_flag", 32'(fetch_misaligned), 32'd1);
    chk("mis_noreq", 32'(imem_req), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mis_hold", 32'(imem_req), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 32'h300);
    chk("mis_clear", 32'(fetch_misaligned), 32'd0);
    chk("mis_resume_req", 32'(imem_req), 32'd1);
    chk("mis_resume_addr", imem_addr, 32'h300);
`else
    chk("mis_flag", 32'(fetch_misaligned), 32'd0);
    chk("mis_req", 32'(imem_req), 32'd1);
    chk("mis_addr", imem_addr, 32'h200);
`endif

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic        g;
      logic        r;
      logic        rd;
      logic [31:0] t;
      cur_lat = $urandom_range(1, 3);
      g  = ($urandom_range(0, 9) < 7);
      r  = ($urandom_range(0, 9) < 6);
      rd = ($urandom_range(0, 19) == 0);
      t  = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
      if (rd && !mem_busy && ($urandom_range(0, 3) == 0)) begin
        t[1:0] = 2'($urandom_range(1, 3));
        g = 1'b0;
      end
      cycle(g, r, rd, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
